// File: rtl/popcount_window_accum.sv
// rtl/popcount_window_accum.sv - windowed accumulator of one-hot population counts with saturation and error flag
module popcount_window_accum #(
    parameter int WINDOW = 16,
    parameter int SUM_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ena,
    input  logic             start,
    input  logic             v,
    input  logic             w,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic [SUM_W-1:0] sum_out,
    output logic             err,
    output logic             done,
    output logic             busy
);

    // Counter only needs to reach WINDOW-1; one extra value keeps WINDOW=1 legal.
    localparam int CNT_W  = $clog2(WINDOW + 1);
    localparam int WIDE_W = SUM_W + 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
    localparam logic [SUM_W-1:0] SUM_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_acc_q, err_acc_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              err_q, err_d;

    logic [2:0]        val;
    logic              illegal;
    logic [WIDE_W-1:0] sum_wide;
    logic [SUM_W-1:0]  acc_sat;
    logic              take_sample;
    logic              last_sample;

    // Decode the one-hot count; anything not exactly one-hot counts as zero and is flagged.
    always_comb begin
        val     = 3'd0;
        illegal = 1'b0;
        case ({v, w, x, y, z})
            5'b10000: val = 3'd0;
            5'b01000: val = 3'd1;
            5'b00100: val = 3'd2;
            5'b00010: val = 3'd3;
            5'b00001: val = 3'd4;
            default:  illegal = 1'b1;
        endcase
    end

    // Saturating add of the current sample onto the running total.
    always_comb begin
        sum_wide    = {3'b000, acc_q} + WIDE_W'(val);
        acc_sat     = (sum_wide > {3'b000, SUM_MAX}) ? SUM_MAX : sum_wide[SUM_W-1:0];
        take_sample = (state_q == S_ACCUM) && ena;
        last_sample = take_sample && (cnt_q == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE waits for start with ena, ACCUM runs WINDOW samples, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && ena) state_d = S_ACCUM;
            S_ACCUM: if (last_sample) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded straight from the registered state.
    always_comb begin
        busy = (state_q == S_ACCUM);
        done = (state_q == S_DONE);
    end

    // Datapath next values: clear on window start, accumulate while sampling, publish on the last sample.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_acc_d = err_acc_q;
        sum_d     = sum_q;
        err_d     = err_q;
        if ((state_q == S_IDLE) && start && ena) begin
            acc_d     = '0;
            cnt_d     = '0;
            err_acc_d = 1'b0;
        end else if (take_sample) begin
            acc_d     = acc_sat;
            cnt_d     = cnt_q + 1'b1;
            err_acc_d = err_acc_q | illegal;
            if (last_sample) begin
                sum_d = acc_sat;
                err_d = err_acc_q | illegal;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            sum_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_acc_q <= err_acc_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
        end
    end

    assign sum_out = sum_q;
    assign err     = err_q;

endmodule

// File: tb/tb_popcount_window_accum.sv
// tb/tb_popcount_window_accum.sv - directed self-checking bench for popcount_window_accum
module tb_popcount_window_accum;

    logic       clk;
    logic       reset_n;
    logic       reset2_n;
    logic       ena;
    logic       start;
    logic       start2;
    logic       v, w, x, y, z;
    logic [7:0] sum_out;
    logic       err, done, busy;
    logic [3:0] sum2;
    logic       err2, done2, busy2;

    int checks;
    int passes;

    popcount_window_accum #(.WINDOW(16), .SUM_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .start(start),
        .v(v), .w(w), .x(x), .y(y), .z(z),
        .sum_out(sum_out), .err(err), .done(done), .busy(busy)
    );

    popcount_window_accum #(.WINDOW(8), .SUM_W(4)) dut2 (
        .clk(clk), .reset_n(reset2_n), .ena(ena), .start(start2),
        .v(v), .w(w), .x(x), .y(y), .z(z),
        .sum_out(sum2), .err(err2), .done(done2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] vwxyz);
        {v, w, x, y, z} = vwxyz;
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        reset_n  = 1'b0;
        reset2_n = 1'b0;
        ena      = 1'b1;
        start    = 1'b1;
        start2   = 1'b1;
        set_in(5'b00001);

        // Reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            step();
            set_in(5'(1 << (i % 5)));
            start = ~start;
        end
        check("rst_sum", sum_out, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);

        // Release with no start: stays idle.
        start  = 1'b0;
        start2 = 1'b0;
        #1;
        reset_n  = 1'b1;
        reset2_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_sum", sum_out, 0);

        // Window of z=1: 16*4 = 64.
        set_in(5'b00001);
        start = 1'b1;
        step();
        start = 1'b0;
        check("z_busy_start", busy, 1);
        for (int i = 0; i < 15; i++) step();
        check("z_busy_15", busy, 1);
        check("z_nodone_15", done, 0);
        step();
        check("z_done", done, 1);
        check("z_busy_at_done", busy, 0);
        check("z_sum", sum_out, 64);
        check("z_err", err, 0);
        step();
        check("z_done_one_cycle", done, 0);
        check("z_idle", busy, 0);

        // Alternate v / y: 8*0 + 8*3 = 24.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_in((i % 2 == 0) ? 5'b10000 : 5'b00010);
            step();
        end
        check("vy_done", done, 1);
        check("vy_sum", sum_out, 24);
        check("vy_err", err, 0);
        step();

        // All w: 16, sum_out holds 24 until done.
        set_in(5'b01000);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("w_hold_sum", sum_out, 24);
        check("w_hold_nodone", done, 0);
        step();
        check("w_done", done, 1);
        check("w_sum", sum_out, 16);
        step();

        // 15 x plus one illegal w+x: 30, err.
        set_in(5'b00100);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        set_in(5'b01100);
        step();
        check("bad_done", done, 1);
        check("bad_sum", sum_out, 30);
        check("bad_err", err, 1);
        step();
        check("bad_err_hold", err, 1);

        // Clean all-v window clears err.
        set_in(5'b10000);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) step();
        check("clean_done", done, 1);
        check("clean_sum", sum_out, 0);
        check("clean_err", err, 0);
        step();

        // Stall 5 cycles mid-window with start pulsed in ACCUM.
        set_in(5'b00001);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        ena = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 5; i++) step();
        start = 1'b0;
        ena   = 1'b1;
        check("stall_busy", busy, 1);
        for (int i = 0; i < 7; i++) step();
        check("stall_nodone", done, 0);
        check("stall_still_busy", busy, 1);
        step();
        check("stall_done", done, 1);
        check("stall_sum", sum_out, 64);
        step();
        step();
        check("stall_no_restart", busy, 0);
        check("stall_no_done", done, 0);

        // Small instance saturates: 8*4 = 32 -> 15.
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("sat_done", done2, 1);
        check("sat_sum", sum2, 15);
        check("sat_err", err2, 0);
        step();

        // Reset at sample 5: immediate IDLE, outputs 0, no done.
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_busy_before", busy2, 1);
        #2;
        reset2_n = 1'b0;
        #1;
        check("mid_rst_busy", busy2, 0);
        check("mid_rst_sum", sum2, 0);
        check("mid_rst_done", done2, 0);
        step();
        reset2_n = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (done2 || busy2) seen_done++;
            end
            check("mid_rst_no_done", seen_done, 0);
        end
        check("mid_rst_sum_after", sum2, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
